// File: rtl/fpu_issue_sequencer.sv
// rtl/fpu_issue_sequencer.sv - single-outstanding FPU issue/writeback sequencer; optional WAIT watchdog under FPU_ISSUE_TIMEOUT_EN
module fpu_issue_sequencer #(
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 23,
  parameter int DEPTH          = 4,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IEEE_W        = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [2:0]          req_rm,
  input  logic [RD_WIDTH-1:0] req_rd,
  input  logic [IEEE_W-1:0]   req_a,
  input  logic [IEEE_W-1:0]   req_b,
  output logic [2:0]          fpu_operator,
  output logic [2:0]          fpu_rounding_mode,
  output logic [IEEE_W-1:0]   fpu_op1,
  output logic [IEEE_W-1:0]   fpu_op2,
  output logic [3:0]          fpu_tag,
  output logic                fpu_in_valid,
  output logic                fpu_cpu_ready,
  input  logic                fpu_ready,
  input  logic                fpu_result_valid,
  input  logic [3:0]          fpu_tag_out,
  input  logic [IEEE_W-1:0]   fpu_result,
  input  logic                fpu_exception,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RD_WIDTH-1:0] wb_rd,
  output logic [IEEE_W-1:0]   wb_data,
  output logic                wb_exc,
  output logic                busy,
  output logic                err_tag,
  output logic                err_timeout,
  output logic                err_spurious,
  input  logic                err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;
  state_t state_q, state_d;

  logic [2:0]          mem_op [DEPTH];
  logic [2:0]          mem_rm [DEPTH];
  logic [RD_WIDTH-1:0] mem_rd [DEPTH];
  logic [IEEE_W-1:0]   mem_a  [DEPTH];
  logic [IEEE_W-1:0]   mem_b  [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                push, pop, empty, full;

  logic [2:0]          op_q, op_d, rm_q, rm_d;
  logic [IEEE_W-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]          tag_q, tag_d, tag_cnt_q, tag_cnt_d;
  logic [RD_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [IEEE_W-1:0]   wb_data_q, wb_data_d;
  logic                wb_exc_q, wb_exc_d;
  logic                err_tag_q, err_spurious_q;
  logic                err_tag_set, spurious_set, timeout_hit;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;

  // FIFO storage; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q] <= req_op;
      mem_rm[wr_ptr_q] <= req_rm;
      mem_rd[wr_ptr_q] <= req_rd;
      mem_a[wr_ptr_q]  <= req_a;
      mem_b[wr_ptr_q]  <= req_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          err_timeout_q;

  assign timeout_hit = (state_q == S_WAIT) && !fpu_result_valid &&
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_timeout_q;

  // Watchdog: counts WAIT cycles from zero, sticky flag on expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
      err_timeout_q <= timeout_hit | (err_timeout_q & ~err_clr);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign spurious_set = fpu_result_valid && (state_q != S_WAIT);

  // Next state, FIFO pop and issue/writeback register loads
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    op_d        = op_q;
    rm_d        = rm_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    tag_cnt_d   = tag_cnt_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_exc_d    = wb_exc_q;
    err_tag_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          wb_rd_d = mem_rd[rd_ptr_q];
          if (mem_op[rd_ptr_q] <= 3'd4) begin
            op_d    = mem_op[rd_ptr_q];
            rm_d    = mem_rm[rd_ptr_q];
            a_d     = mem_a[rd_ptr_q];
            b_d     = mem_b[rd_ptr_q];
            tag_d   = tag_cnt_q;
            state_d = S_ISSUE;
          end else begin
            // Unsupported opcode: retire locally with an exception, never reaches the FPU
            pop       = 1'b1;
            wb_data_d = '0;
            wb_exc_d  = 1'b1;
            state_d   = S_WB;
          end
        end
      end
      S_ISSUE: begin
        if (fpu_ready) begin
          pop       = 1'b1;
          tag_cnt_d = tag_cnt_q + 4'd1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_result_valid) begin
          wb_data_d   = fpu_result;
          wb_exc_d    = fpu_exception;
          err_tag_set = (fpu_tag_out != tag_q);
          state_d     = S_WB;
        end else if (timeout_hit) begin
          wb_data_d = '0;
          wb_exc_d  = 1'b1;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, issue registers, writeback registers and sticky flags (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      rm_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      tag_q          <= '0;
      tag_cnt_q      <= '0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_exc_q       <= 1'b0;
      err_tag_q      <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rm_q           <= rm_d;
      a_q            <= a_d;
      b_q            <= b_d;
      tag_q          <= tag_d;
      tag_cnt_q      <= tag_cnt_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_exc_q       <= wb_exc_d;
      err_tag_q      <= err_tag_set | (err_tag_q & ~err_clr);
      err_spurious_q <= spurious_set | (err_spurious_q & ~err_clr);
    end
  end

  assign fpu_operator      = op_q;
  assign fpu_rounding_mode = rm_q;
  assign fpu_op1           = a_q;
  assign fpu_op2           = b_q;
  assign fpu_tag           = tag_q;
  assign fpu_in_valid      = (state_q == S_ISSUE);
  assign fpu_cpu_ready     = fpu_in_valid;
  assign wb_valid          = (state_q == S_WB);
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign wb_exc            = wb_exc_q;
  assign busy              = !empty || (state_q != S_IDLE);
  assign err_tag           = err_tag_q;
  assign err_spurious      = err_spurious_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// tb/tb_fpu_issue_sequencer.sv - scoreboard bench for fpu_issue_sequencer with a stub FPU
module tb_fpu_issue_sequencer;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0, req_rm = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  fpu_operator, fpu_rounding_mode;
  logic [31:0] fpu_op1, fpu_op2;
  logic [3:0]  fpu_tag;
  logic        fpu_in_valid, fpu_cpu_ready;
  logic        fpu_ready = 1'b1;
  logic        fpu_result_valid = 1'b0;
  logic [3:0]  fpu_tag_out = '0;
  logic [31:0] fpu_result = '0;
  logic        fpu_exception = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exc, busy, err_tag, err_timeout, err_spurious;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  wb_t        exp_q[$];
  wb_t        obs_q[$];
  logic [3:0] issued_tags[$];
  int         in_valid_cycles = 0;

  int          stub_lat = 2;
  int          stub_tag_force = -1;
  logic        stub_silent = 1'b0;
  logic        force_pulse = 1'b0;
  logic        wb_bp = 1'b0;
  logic        pend = 1'b0;
  logic        xfer;
  int          cnt = 0;
  logic [2:0]  cap_op;
  logic [31:0] cap_a, cap_b;
  logic [3:0]  cap_tag;

  fpu_issue_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_rd(req_rd), .req_a(req_a), .req_b(req_b),
    .fpu_operator(fpu_operator), .fpu_rounding_mode(fpu_rounding_mode),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_tag(fpu_tag),
    .fpu_in_valid(fpu_in_valid), .fpu_cpu_ready(fpu_cpu_ready), .fpu_ready(fpu_ready),
    .fpu_result_valid(fpu_result_valid), .fpu_tag_out(fpu_tag_out),
    .fpu_result(fpu_result), .fpu_exception(fpu_exception),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exc(wb_exc), .busy(busy), .err_tag(err_tag), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] stub_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
    else r = (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
    return {a[0] ^ b[0], r};
  endfunction

  // Stub FPU and observers: sample pre-edge values, respond 1 time unit after the edge
  always @(posedge clk) begin
    xfer = !reset && fpu_in_valid && fpu_ready;
    if (xfer) begin
      cap_op = fpu_operator; cap_a = fpu_op1; cap_b = fpu_op2; cap_tag = fpu_tag;
      issued_tags.push_back(fpu_tag);
    end
    if (!reset && fpu_in_valid) in_valid_cycles++;
    if (!reset && wb_valid && wb_ready) obs_q.push_back({wb_rd, wb_data, wb_exc});
    #1;
    fpu_result_valid = 1'b0;
    if (reset) pend = 1'b0;
    if (force_pulse) begin
      fpu_result_valid = 1'b1; fpu_tag_out = 4'd0; fpu_result = 32'hDEADBEEF; fpu_exception = 1'b0;
      force_pulse = 1'b0;
    end else if (pend && !stub_silent) begin
      if (cnt <= 1) begin
        {fpu_exception, fpu_result} = stub_fn(cap_op, cap_a, cap_b);
        fpu_tag_out = (stub_tag_force >= 0) ? stub_tag_force[3:0] : cap_tag;
        fpu_result_valid = 1'b1;
        pend = 1'b0;
      end else cnt--;
    end
    if (xfer) begin pend = 1'b1; cnt = stub_lat; end
  end

  // Random writeback backpressure when enabled
  always @(posedge clk) begin
    #2;
    if (wb_bp) wb_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; fpu_ready = 1'b1; wb_ready = 1'b1; wb_bp = 1'b0;
    err_clr = 1'b0; stub_silent = 1'b0; stub_tag_force = -1; stub_lat = 2; force_pulse = 1'b0;
    tick(); tick();
    exp_q.delete(); obs_q.delete(); issued_tags.delete(); in_valid_cycles = 0;
    reset = 1'b0;
    tick();
  endtask

  task automatic push_req(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] f;
    logic done;
    done = 1'b0;
    req_valid = 1'b1; req_op = op; req_rm = rd[2:0]; req_rd = rd; req_a = a; req_b = b;
    for (int t = 0; t < 200 && !done; t++) begin
      if (req_ready) done = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    n_checks++; if (!done) $display("FAIL push_accept timeout op=%0d rd=%0d", op, rd); else n_pass++;
    if (done) begin
      f = stub_fn(op, a, b);
      exp_q.push_back((op <= 3'd4) ? {rd, f[31:0], f[32]} : {rd, 32'd0, 1'b1});
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (fpu_in_valid !== 1'b0 || fpu_cpu_ready !== 1'b0) $display("FAIL reset_fpu_valid got=%b%b exp=00", fpu_in_valid, fpu_cpu_ready); else n_pass++;
    n_checks++; if ({fpu_operator, fpu_rounding_mode, fpu_op1, fpu_op2, fpu_tag} !== '0) $display("FAIL reset_fpu_outs got=%h %h %h %h %h exp=0", fpu_operator, fpu_rounding_mode, fpu_op1, fpu_op2, fpu_tag); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); else n_pass++;
    n_checks++; if ({wb_rd, wb_data, wb_exc} !== '0) $display("FAIL reset_wb_outs got=%h %h %b exp=0", wb_rd, wb_data, wb_exc); else n_pass++;
    n_checks++; if ({err_tag, err_timeout, err_spurious} !== 3'b000) $display("FAIL reset_err got=%b%b%b exp=000", err_tag, err_timeout, err_spurious); else n_pass++;
  endtask

  task automatic test_single_add();
    wb_t w, e;
    do_reset();
    stub_lat = 3;
    push_req(3'd0, 5'd5, 32'h3F800000, 32'h40000000);
    n_checks++; if (fpu_in_valid !== 1'b0) $display("FAIL add_idle_cycle fpu_in_valid got=%b exp=0", fpu_in_valid); else n_pass++;
    tick();
    n_checks++; if (fpu_in_valid !== 1'b1 || fpu_cpu_ready !== 1'b1) $display("FAIL add_issue_latency got=%b%b exp=11", fpu_in_valid, fpu_cpu_ready); else n_pass++;
    n_checks++; if ({fpu_operator, fpu_rounding_mode, fpu_tag} !== {3'd0, 3'd5, 4'd0}) $display("FAIL add_issue_fields got op=%0d rm=%0d tag=%0d exp op=0 rm=5 tag=0", fpu_operator, fpu_rounding_mode, fpu_tag); else n_pass++;
    n_checks++; if (fpu_op1 !== 32'h3F800000 || fpu_op2 !== 32'h40000000) $display("FAIL add_operands got=%h %h exp=3f800000 40000000", fpu_op1, fpu_op2); else n_pass++;
    for (int t = 0; t < 50 && !fpu_result_valid; t++) tick();
    n_checks++; if (!fpu_result_valid) $display("FAIL add_result_pulse timeout"); else n_pass++;
    tick();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL add_wb_latency got=%b exp=1", wb_valid); else n_pass++;
    n_checks++; if ({wb_rd, wb_data, wb_exc} !== {5'd5, 32'h40400000, 1'b0}) $display("FAIL add_wb_fields got rd=%0d data=%h exc=%b exp rd=5 data=40400000 exc=0", wb_rd, wb_data, wb_exc); else n_pass++;
    tick();
    n_checks++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL add_sb_count got=%0d exp=1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      w = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL add_sb_entry got=%h exp=%h", w, e); else n_pass++;
    end
    push_req(3'd1, 5'd6, $urandom, $urandom);
    for (int t = 0; t < 50 && !fpu_in_valid; t++) tick();
    n_checks++; if (fpu_tag !== 4'd1) $display("FAIL add_second_tag got=%0d exp=1", fpu_tag); else n_pass++;
    for (int t = 0; t < 100 && obs_q.size() == 0; t++) tick();
    n_checks++; if (obs_q.size() != 1) $display("FAIL sub_wb timeout got=%0d exp=1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      w = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL sub_sb_entry got=%h exp=%h", w, e); else n_pass++;
    end
    n_checks++; if ({err_tag, err_spurious} !== 2'b00) $display("FAIL add_err got=%b%b exp=00", err_tag, err_spurious); else n_pass++;
  endtask

  task automatic test_back_to_back();
    wb_t w, e;
    logic [3:0] tg;
    do_reset();
    fpu_ready = 1'b0;
    stub_lat = 1;
    for (int i = 0; i < 4; i++) push_req(3'(i), 5'(10 + i), $urandom, $urandom);
    req_valid = 1'b1; req_op = 3'd4; req_rd = 5'd20; req_a = $urandom; req_b = $urandom;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_full got=%b exp=0", req_ready); else n_pass++;
    tick();
    n_checks++; if (req_ready !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_full_hold got ready=%b busy=%b exp 0 1", req_ready, busy); else n_pass++;
    req_valid = 1'b0;
    wb_bp = 1'b1;
    fpu_ready = 1'b1;
    for (int t = 0; t < 400 && obs_q.size() < 4; t++) tick();
    wb_bp = 1'b0; wb_ready = 1'b1;
    n_checks++; if (obs_q.size() != 4) $display("FAIL b2b_wb_count got=%0d exp=4", obs_q.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        w = obs_q.pop_front(); e = exp_q.pop_front();
        n_checks++; if (w !== e) $display("FAIL b2b_entry%0d got=%h exp=%h", i, w, e); else n_pass++;
      end
      if (issued_tags.size() > 0) begin
        tg = issued_tags.pop_front();
        n_checks++; if (tg !== 4'(i)) $display("FAIL b2b_tag%0d got=%0d exp=%0d", i, tg, i); else n_pass++;
      end
    end
    n_checks++; if ({err_tag, err_timeout, err_spurious} !== 3'b000) $display("FAIL b2b_err got=%b%b%b exp=000", err_tag, err_timeout, err_spurious); else n_pass++;
  endtask

  task automatic test_invalid_op();
    wb_t w, e;
    do_reset();
    push_req(3'd6, 5'd9, $urandom, $urandom);
    for (int t = 0; t < 50 && obs_q.size() == 0; t++) tick();
    n_checks++; if (obs_q.size() != 1) $display("FAIL inv_wb timeout got=%0d exp=1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      w = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (w !== {5'd9, 32'd0, 1'b1}) $display("FAIL inv_entry got=%h exp rd=9 data=0 exc=1", w); else n_pass++;
      n_checks++; if (w !== e) $display("FAIL inv_sb_entry got=%h exp=%h", w, e); else n_pass++;
    end
    tick();
    n_checks++; if (in_valid_cycles != 0) $display("FAIL inv_no_issue got=%0d exp=0", in_valid_cycles); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL inv_idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_tag_error();
    wb_t w, e;
    do_reset();
    stub_tag_force = 7;
    push_req(3'd2, 5'd12, $urandom, $urandom);
    for (int t = 0; t < 50 && obs_q.size() == 0; t++) tick();
    n_checks++; if (obs_q.size() != 1) $display("FAIL tag_wb timeout got=%0d exp=1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      w = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (w !== e) $display("FAIL tag_data got=%h exp=%h", w, e); else n_pass++;
    end
    n_checks++; if (err_tag !== 1'b1) $display("FAIL tag_err_set got=%b exp=1", err_tag); else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err_tag !== 1'b0) $display("FAIL tag_err_clr got=%b exp=0", err_tag); else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    force_pulse = 1'b1;
    tick(); tick();
    n_checks++; if (err_spurious !== 1'b1) $display("FAIL spur_idle got=%b exp=1", err_spurious); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0 || obs_q.size() != 0) $display("FAIL spur_no_wb got valid=%b n=%0d exp 0 0", wb_valid, obs_q.size()); else n_pass++;
  endtask

`ifdef FPU_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    wb_t w;
    do_reset();
    stub_silent = 1'b1;
    push_req(3'd3, 5'd3, $urandom, $urandom);
    for (int t = 0; t < 50 && !fpu_in_valid; t++) tick();
    n_checks++; if (!fpu_in_valid) $display("FAIL to_issue timeout"); else n_pass++;
    tick();
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (wb_valid !== 1'b0 || err_timeout !== 1'b0) $display("FAIL to_early got valid=%b err=%b exp 0 0", wb_valid, err_timeout); else n_pass++;
    tick();
    n_checks++; if (wb_valid !== 1'b1 || err_timeout !== 1'b1 || wb_exc !== 1'b1 || wb_data !== 32'd0) $display("FAIL to_expire got valid=%b err=%b exc=%b data=%h exp 1 1 1 0", wb_valid, err_timeout, wb_exc, wb_data); else n_pass++;
    tick();
    if (obs_q.size() > 0) begin
      w = obs_q.pop_front();
      n_checks++; if (w !== {5'd3, 32'd0, 1'b1}) $display("FAIL to_entry got=%h exp rd=3 data=0 exc=1", w); else n_pass++;
    end
    exp_q.delete();
    force_pulse = 1'b1;
    tick(); tick();
    n_checks++; if (err_spurious !== 1'b1) $display("FAIL to_late_pulse got=%b exp=1", err_spurious); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    stub_silent = 1'b1;
    push_req(3'd0, 5'd7, $urandom, $urandom);
    for (int t = 0; t < 50 && !fpu_in_valid; t++) tick();
    tick(); tick();
    reset = 1'b1;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_mid_status got valid=%b busy=%b ready=%b exp 0 0 1", wb_valid, busy, req_ready); else n_pass++;
    n_checks++; if ({fpu_in_valid, fpu_op1, fpu_tag, wb_data, wb_rd} !== '0) $display("FAIL rst_mid_outs got in_valid=%b op1=%h tag=%0d wb_data=%h wb_rd=%0d exp 0", fpu_in_valid, fpu_op1, fpu_tag, wb_data, wb_rd); else n_pass++;
    tick();
    reset = 1'b0;
    stub_silent = 1'b0;
    force_pulse = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (err_spurious !== 1'b1) $display("FAIL rst_mid_spurious got=%b exp=1", err_spurious); else n_pass++;
    n_checks++; if (obs_q.size() != 0 || busy !== 1'b0) $display("FAIL rst_mid_no_wb got n=%0d busy=%b exp 0 0", obs_q.size(), busy); else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_invalid_op();
    test_tag_error();
    test_spurious();
`ifdef FPU_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
